// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates the single register-file write port among three writeback
//   sources (ALU, load return, mul/div) and keeps a pending-write scoreboard
//   for long-latency destinations.
//
//   Build option: REGFILE_WB_RR_FAIR_EN
//     undefined : fixed priority alu > ld > md
//     defined   : alu first, then ld/md by a shared 1-bit round-robin pointer
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   stall                       pipeline stall (also gates the regfile write)
//   alu_/ld_/md_valid,addr,data writeback requests
//   alu_/ld_/md_ready           request accepted this cycle
//   iss_valid, iss_addr         long-latency op issued (sets scoreboard)
//   rs_addr_q, rt_addr_q        decode-stage source addresses
//   rs_busy, rt_busy            source has an outstanding long-latency write
//   wb_addr, wb_data            regfile write port (address 0 = no write)
//   busy_mask                   scoreboard contents (debug)
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_addr,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   ld_valid,
    input  logic [ADDR_W-1:0]      ld_addr,
    input  logic [DATA_W-1:0]      ld_data,
    output logic                   ld_ready,
    input  logic                   md_valid,
    input  logic [ADDR_W-1:0]      md_addr,
    input  logic [DATA_W-1:0]      md_data,
    output logic                   md_ready,
    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_addr,
    input  logic [ADDR_W-1:0]      rs_addr_q,
    input  logic [ADDR_W-1:0]      rt_addr_q,
    output logic                   rs_busy,
    output logic                   rt_busy,
    output logic [ADDR_W-1:0]      wb_addr,
    output logic [DATA_W-1:0]      wb_data,
    output logic [(1<<ADDR_W)-1:0] busy_mask
);

    localparam int NREG = 1 << ADDR_W;

    logic            aluHs;
    logic            ldHs;
    logic            mdHs;
    logic [NREG-1:0] busyNext;

`ifdef REGFILE_WB_RR_FAIR_EN
    typedef enum logic {PTR_LD = 1'b0, PTR_MD = 1'b1} rrPtr_e;
    rrPtr_e rrPtrQ;
    rrPtr_e rrPtrNext;
`endif

    // Each ready is the "you would win if you were valid" signal, built only
    // from higher-priority valids and stall; it never looks at its own valid.
    // Ready may therefore be high on an idle source, but only one valid
    // source ever sees ready, so at most one handshake occurs per cycle.
    always_comb begin
        alu_ready = ~stall;
`ifdef REGFILE_WB_RR_FAIR_EN
        ld_ready  = ~stall & ~alu_valid & ((rrPtrQ == PTR_LD) | ~md_valid);
        md_ready  = ~stall & ~alu_valid & ((rrPtrQ == PTR_MD) | ~ld_valid);
`else
        ld_ready  = ~stall & ~alu_valid;
        md_ready  = ~stall & ~alu_valid & ~ld_valid;
`endif
    end

    assign aluHs = alu_valid & alu_ready;
    assign ldHs  = ld_valid  & ld_ready;
    assign mdHs  = md_valid  & md_ready;

`ifdef REGFILE_WB_RR_FAIR_EN
    always_comb begin
        rrPtrNext = rrPtrQ;
        if (ldHs)
            rrPtrNext = PTR_MD;
        else if (mdHs)
            rrPtrNext = PTR_LD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rrPtrQ <= PTR_LD;
        else
            rrPtrQ <= rrPtrNext;
    end
`endif

    // Write port register. Under stall both fields hold so the pending write
    // commits once on the first unstalled cycle; the following edge then
    // loads a new write or address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_addr <= '0;
            wb_data <= '0;
        end else if (!stall) begin
            if (aluHs) begin
                wb_addr <= alu_addr;
                wb_data <= alu_data;
            end else if (ldHs) begin
                wb_addr <= ld_addr;
                wb_data <= ld_data;
            end else if (mdHs) begin
                wb_addr <= md_addr;
                wb_data <= md_data;
            end else begin
                wb_addr <= '0;
            end
        end
    end

    // Scoreboard: clear first, then set, so a same-address set wins.
    always_comb begin
        busyNext = busy_mask;
        if (ldHs)
            busyNext[ld_addr] = 1'b0;
        else if (mdHs)
            busyNext[md_addr] = 1'b0;
        if (iss_valid && !stall && (iss_addr != '0))
            busyNext[iss_addr] = 1'b1;
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_mask <= '0;
        else
            busy_mask <= busyNext;
    end

    // Entry 0 is never set, so address 0 always reads not-busy.
    assign rs_busy = busy_mask[rs_addr_q];
    assign rt_busy = busy_mask[rt_addr_q];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a table of per-cycle vectors
// (inputs plus expected winner), a queue of expected writeback values pushed
// when stimulus is driven and popped one cycle later, and hand sequences for
// stall/reset and ld/md fairness.
module tb_regfile_wb_arbiter;

    localparam int W_NONE = 0;
    localparam int W_ALU  = 1;
    localparam int W_LD   = 2;
    localparam int W_MD   = 3;

`ifdef REGFILE_WB_RR_FAIR_EN
    localparam int RR_W2 = W_MD;
`else
    localparam int RR_W2 = W_LD;
`endif

    typedef struct packed {
        logic        st;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ldd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] mdd;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  rs;
        logic [4:0]  rt;
        int          win;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        c;
    } wbExp_t;

    logic        clk, rst, stall;
    logic        alu_valid, ld_valid, md_valid;
    logic [4:0]  alu_addr, ld_addr, md_addr;
    logic [31:0] alu_data, ld_data, md_data;
    logic        alu_ready, ld_ready, md_ready;
    logic        iss_valid;
    logic [4:0]  iss_addr, rs_addr_q, rt_addr_q;
    logic        rs_busy, rt_busy;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] busy_mask;

    int checks   = 0;
    int failures = 0;

    wbExp_t      wbQ[$];
    logic [4:0]  expAddr;
    logic [31:0] expData;
    logic        dataKnown;
    logic [31:0] sbExp;

    vec_t tbl[23];
    vec_t rrSeq[4];

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .rs_addr_q(rs_addr_q), .rt_addr_q(rt_addr_q),
        .rs_busy(rs_busy), .rt_busy(rt_busy),
        .wb_addr(wb_addr), .wb_data(wb_data), .busy_mask(busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic st, input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic lv, input logic [4:0] la, input logic [31:0] ldd,
        input logic mv, input logic [4:0] ma, input logic [31:0] mdd,
        input logic iv, input logic [4:0] ia, input logic [4:0] rs, input logic [4:0] rt,
        input int win);
        vec_t v;
        v.st = st; v.av = av; v.aa = aa; v.ad = ad;
        v.lv = lv; v.la = la; v.ldd = ldd;
        v.mv = mv; v.ma = ma; v.mdd = mdd;
        v.iv = iv; v.ia = ia; v.rs = rs; v.rt = rt; v.win = win;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic resetModel();
        expAddr   = '0;
        expData   = '0;
        dataKnown = 1'b1;
        sbExp     = '0;
        wbQ.delete();
    endtask

    // Called at posedge+1; drives one cycle, checks readys/busy flags before
    // the edge and the registered outputs after it.
    task automatic applyVec(input vec_t v, input int idx);
        logic [2:0]  vmask, emask, amask;
        logic [31:0] sbNext;
        wbExp_t      e, got;
        stall     = v.st;
        alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
        ld_valid  = v.lv; ld_addr  = v.la; ld_data  = v.ldd;
        md_valid  = v.mv; md_addr  = v.ma; md_data  = v.mdd;
        iss_valid = v.iv; iss_addr = v.ia;
        rs_addr_q = v.rs; rt_addr_q = v.rt;
        #1;
        amask = {alu_ready, ld_ready, md_ready};
        if (v.st) begin
            chk($sformatf("ready_stall[%0d]", idx), {61'd0, amask}, 64'd0);
        end else begin
            vmask = {v.av, v.lv, v.mv};
            emask = {v.win == W_ALU, v.win == W_LD, v.win == W_MD};
            chk($sformatf("alu_ready[%0d]", idx), {63'd0, alu_ready}, 64'd1);
            chk($sformatf("grant[%0d]", idx), {61'd0, amask & vmask}, {61'd0, emask});
        end
        chk($sformatf("rs_busy[%0d]", idx), {63'd0, rs_busy}, {63'd0, sbExp[v.rs]});
        chk($sformatf("rt_busy[%0d]", idx), {63'd0, rt_busy}, {63'd0, sbExp[v.rt]});

        sbNext = sbExp;
        if (!v.st) begin
            case (v.win)
                W_ALU: begin expAddr = v.aa; expData = v.ad;  end
                W_LD:  begin expAddr = v.la; expData = v.ldd; sbNext[v.la] = 1'b0; end
                W_MD:  begin expAddr = v.ma; expData = v.mdd; sbNext[v.ma] = 1'b0; end
                default: expAddr = '0;
            endcase
            if (v.win != W_NONE)
                dataKnown = (expAddr != '0);
            if (v.iv && v.ia != '0)
                sbNext[v.ia] = 1'b1;
        end
        e.a = expAddr; e.d = expData; e.c = dataKnown;
        wbQ.push_back(e);

        @(posedge clk);
        #1;
        sbExp = sbNext;
        if (wbQ.size() == 0) begin
            chk($sformatf("wb_queue[%0d]", idx), 64'd0, 64'd1);
        end else begin
            got = wbQ.pop_front();
            chk($sformatf("wb_addr[%0d]", idx), {59'd0, wb_addr}, {59'd0, got.a});
            if (got.c)
                chk($sformatf("wb_data[%0d]", idx), {32'd0, wb_data}, {32'd0, got.d});
        end
        chk($sformatf("busy_mask[%0d]", idx), {32'd0, busy_mask}, {32'd0, sbExp});
    endtask

    initial begin
        // st av aa ad            lv la ldd           mv ma mdd           iv ia  rs rt  win
        tbl[0]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0, 0,        0, 0,  0, 0,  W_ALU);
        tbl[1]  = mk(0, 0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0,  0, 0,  W_NONE);
        tbl[2]  = mk(0, 1, 3, 32'hA3,       1, 4, 32'hB4,   1, 6, 32'hC6,   0, 0,  0, 0,  W_ALU);
        tbl[3]  = mk(0, 0, 0, 0,            1, 4, 32'hB4,   1, 6, 32'hC6,   0, 0,  0, 0,  W_LD);
        tbl[4]  = mk(0, 0, 0, 0,            0, 0, 0,        1, 6, 32'hC6,   0, 0,  0, 0,  W_MD);
        tbl[5]  = mk(0, 0, 0, 0,            0, 0, 0,        0, 0, 0,        1, 7,  7, 0,  W_NONE);
        tbl[6]  = mk(0, 0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0,  7, 0,  W_NONE);
        tbl[7]  = mk(0, 0, 0, 0,            1, 7, 32'h77,   0, 0, 0,        0, 0,  7, 0,  W_LD);
        tbl[8]  = mk(0, 0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0,  7, 0,  W_NONE);
        tbl[9]  = mk(0, 0, 0, 0,            0, 0, 0,        0, 0, 0,        1, 9,  0, 9,  W_NONE);
        tbl[10] = mk(0, 0, 0, 0,            0, 0, 0,        1, 9, 32'h99,   1, 9,  0, 9,  W_MD);
        tbl[11] = mk(0, 0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0,  0, 9,  W_NONE);
        tbl[12] = mk(0, 0, 0, 0,            0, 0, 0,        1, 9, 32'h98,   0, 0,  0, 9,  W_MD);
        tbl[13] = mk(0, 0, 0, 0,            0, 0, 0,        0, 0, 0,        1, 0,  0, 9,  W_NONE);
        tbl[14] = mk(0, 1, 0, 32'h55,       0, 0, 0,        0, 0, 0,        0, 0,  0, 0,  W_ALU);
        tbl[15] = mk(1, 0, 0, 0,            0, 0, 0,        0, 0, 0,        1, 13, 13, 0, W_NONE);
        tbl[16] = mk(0, 0, 0, 0,            1, 4, 32'h1234, 0, 0, 0,        0, 0,  13, 0, W_LD);
        tbl[17] = mk(1, 0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0,  0, 0,  W_NONE);
        tbl[18] = mk(1, 0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0,  0, 0,  W_NONE);
        tbl[19] = mk(1, 0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0,  0, 0,  W_NONE);
        tbl[20] = mk(0, 0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0,  0, 0,  W_NONE);
        tbl[21] = mk(0, 1, 8, 32'h88,       0, 0, 0,        1, 2, 32'h22,   0, 0,  0, 0,  W_ALU);
        tbl[22] = mk(0, 0, 0, 0,            0, 0, 0,        1, 2, 32'h22,   0, 0,  0, 0,  W_MD);

        rrSeq[0] = mk(0, 0, 0, 0, 1, 10, 32'hA10, 1, 11, 32'hB11, 0, 0, 0, 0, W_LD);
        rrSeq[1] = mk(0, 0, 0, 0, 1, 10, 32'hA10, 1, 11, 32'hB11, 0, 0, 0, 0, RR_W2);
        rrSeq[2] = mk(0, 0, 0, 0, 1, 10, 32'hA10, 1, 11, 32'hB11, 0, 0, 0, 0, W_LD);
        rrSeq[3] = mk(0, 0, 0, 0, 0, 0,  0,       0, 0,  0,       0, 0, 0, 0, W_NONE);

        // Reset state
        rst = 1'b1; stall = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0;
        md_valid  = 1'b0; md_addr  = '0; md_data  = '0;
        iss_valid = 1'b0; iss_addr = '0;
        rs_addr_q = 5'd7; rt_addr_q = 5'd9;
        resetModel();
        #3;
        chk("rst_wb_addr", {59'd0, wb_addr}, 64'd0);
        chk("rst_wb_data", {32'd0, wb_data}, 64'd0);
        chk("rst_busy_mask", {32'd0, busy_mask}, 64'd0);
        chk("rst_rs_busy", {63'd0, rs_busy}, 64'd0);
        chk("rst_rt_busy", {63'd0, rt_busy}, 64'd0);
        #9 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++)
            applyVec(tbl[i], i);

        // Reset asserted during a stalled pending write must clear at once.
        applyVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20, 0, 0, W_NONE), 100);
        applyVec(mk(0, 0, 0, 0, 1, 4, 32'hCAFE, 0, 0, 0, 0, 0, 20, 0, W_LD), 101);
        applyVec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 20, 0, W_NONE), 102);
        chk("pre_rst_wb_addr", {59'd0, wb_addr}, 64'd4);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_wb_addr", {59'd0, wb_addr}, 64'd0);
        chk("async_rst_wb_data", {32'd0, wb_data}, 64'd0);
        chk("async_rst_busy_mask", {32'd0, busy_mask}, 64'd0);
        chk("async_rst_rs_busy", {63'd0, rs_busy}, 64'd0);
        stall = 1'b0;
        resetModel();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // ld and md held valid together from a fresh pointer.
        for (int i = 0; i < 4; i++)
            applyVec(rrSeq[i], 200 + i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
